// File: rtl/step_sequencer.sv
// Four-phase CPU clock generator with a one-hot instruction step ring and run/halt/single-step control.
// Define STEP_SEQ_INSTR_COUNT_EN to add a 16-bit wrapping completed-instruction counter output.
module step_sequencer #(
  parameter int NUM_STEPS = 7
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 single_step,
  output logic                 clk,
  output logic                 clk_e,
  output logic                 clk_s,
  output logic [NUM_STEPS-1:0] step,
  output logic                 instr_done,
`ifdef STEP_SEQ_INSTR_COUNT_EN
  output logic [15:0]          instr_count,
`endif
  output logic                 running
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_DRAINING = 2'd2
  } state_t;

  localparam logic [NUM_STEPS-1:0] STEP_FIRST = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [1:0]           r_phase;
  logic [NUM_STEPS-1:0] r_step;
  logic                 r_clk;
  logic                 r_clk_e;
  logic                 r_clk_s;
  logic                 r_instr_done;
  logic                 r_running;

  state_t               w_next_state;
  logic [1:0]           w_next_phase;
  logic [NUM_STEPS-1:0] w_next_step;
  logic                 w_last;
  logic                 w_active;

  // Last phase of the last step: the only point where an instruction may end.
  assign w_last = (r_phase == 2'd3) && r_step[NUM_STEPS-1];

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_next_state = r_state;
    w_next_phase = r_phase + 2'd1;
    w_next_step  = (r_phase == 2'd3) ? {r_step[NUM_STEPS-2:0], r_step[NUM_STEPS-1]} : r_step;
    unique case (r_state)
      ST_STOPPED: begin
        w_next_phase = 2'd0;
        w_next_step  = STEP_FIRST;
        if (run)              w_next_state = ST_RUNNING;
        else if (single_step) w_next_state = ST_DRAINING;
      end
      ST_RUNNING: begin
        if (halt_req || !run) w_next_state = w_last ? ST_STOPPED : ST_DRAINING;
      end
      ST_DRAINING: begin
        if (w_last) w_next_state = ST_STOPPED;
      end
      default: begin
        w_next_state = ST_STOPPED;
        w_next_phase = 2'd0;
        w_next_step  = STEP_FIRST;
      end
    endcase
  end

  assign w_active = (w_next_state != ST_STOPPED);

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_STOPPED;
      r_phase      <= 2'd0;
      r_step       <= STEP_FIRST;
      r_clk        <= 1'b0;
      r_clk_e      <= 1'b0;
      r_clk_s      <= 1'b0;
      r_instr_done <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_state      <= w_next_state;
      r_phase      <= w_next_phase;
      r_step       <= w_next_step;
      r_clk        <= w_active && (w_next_phase <= 2'd1);
      r_clk_e      <= w_active && (w_next_phase != 2'd3);
      r_clk_s      <= w_active && (w_next_phase == 2'd1);
      r_instr_done <= w_active && (w_next_phase == 2'd3) && w_next_step[NUM_STEPS-1];
      r_running    <= w_active;
    end
  end

  assign clk        = r_clk;
  assign clk_e      = r_clk_e;
  assign clk_s      = r_clk_s;
  assign step       = r_step;
  assign instr_done = r_instr_done;
  assign running    = r_running;

`ifdef STEP_SEQ_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)             r_instr_count <= 16'd0;
    else if (r_instr_done) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: a cycle-index model of the instruction predicts every output.
// Define STEP_SEQ_INSTR_COUNT_EN for both files to also check the instruction counter.
module tb_step_sequencer;

  localparam int N     = 7;
  localparam int TOTAL = 4 * N;
  localparam int LAST  = TOTAL - 1;

  logic         sys_clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         halt_req = 1'b0;
  logic         single_step = 1'b0;
  logic         clk, clk_e, clk_s, instr_done, running;
  logic [N-1:0] step;
`ifdef STEP_SEQ_INSTR_COUNT_EN
  logic [15:0]  instr_count;
`endif

  int total = 0;
  int bad   = 0;

  // Model: an instruction is TOTAL sys_clk cycles indexed 0..LAST; phase = idx%4, step = idx/4.
  bit m_stopped = 1'b1;
  bit m_pending = 1'b0;
  int m_idx     = 0;
  int m_count   = 0;

  step_sequencer #(.NUM_STEPS(N)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .run        (run),
    .halt_req   (halt_req),
    .single_step(single_step),
    .clk        (clk),
    .clk_e      (clk_e),
    .clk_s      (clk_s),
    .step       (step),
    .instr_done (instr_done),
`ifdef STEP_SEQ_INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .running    (running)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [N+4:0] exp_vec();
    logic [N-1:0] one;
    logic [N-1:0] st;
    logic [1:0]   ph;
    one = 1;
    if (m_stopped) return {3'b000, one, 1'b0, 1'b0};
    ph = m_idx[1:0];
    st = one << (m_idx / 4);
    return {ph <= 2'd1, ph != 2'd3, ph == 2'd1, st, m_idx == LAST, 1'b1};
  endfunction

  function automatic logic [N+4:0] obs_vec();
    return {clk, clk_e, clk_s, step, instr_done, running};
  endfunction

  task automatic model_reset();
    m_stopped = 1'b1;
    m_pending = 1'b0;
    m_idx     = 0;
    m_count   = 0;
  endtask

  // Advance one sys_clk, update the model from the inputs seen at that edge, then settle.
  task automatic tick();
    @(posedge sys_clk);
    if (!reset) begin
      if (!m_stopped && m_idx == LAST) m_count = (m_count + 1) % 65536;
      if (m_stopped) begin
        if (run) begin
          m_stopped = 1'b0; m_pending = 1'b0; m_idx = 0;
        end else if (single_step) begin
          m_stopped = 1'b0; m_pending = 1'b1; m_idx = 0;
        end
      end else begin
        if (halt_req || !run) m_pending = 1'b1;
        if (m_idx == LAST && m_pending) m_stopped = 1'b1;
        m_idx = (m_idx + 1) % TOTAL;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; halt_req = 1'b0; single_step = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [N-1:0] one;
    one = 1;
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== {3'b000, one, 2'b00}) begin
      bad++; $display("FAIL reset_async got=%b want=%b", obs_vec(), {3'b000, one, 2'b00});
    end
    run = 1'b1;
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_held got=%b want=%b", obs_vec(), exp_vec());
    end
    run = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_free_run();
    int done_cnt = 0;
    int done_at  = -1;
    logic [3:0] e_pat, s_pat;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= TOTAL; i++) begin
      if (i == TOTAL) run = 1'b0;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL free_run cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
      e_pat = {e_pat[2:0], clk_e};
      s_pat = {s_pat[2:0], clk_s};
      if (i % 4 == 0) begin
        total++;
        if (e_pat !== 4'b1110 || s_pat !== 4'b0100 || step !== (N'(1) << (i / 4 - 1))) begin
          bad++; $display("FAIL free_run_pattern step=%0d got e=%b s=%b st=%b want e=1110 s=0100", i / 4, e_pat, s_pat, step);
        end
      end
      if (instr_done) begin done_cnt++; done_at = i; end
    end
    total++;
    if (done_cnt !== 1 || done_at !== TOTAL) begin
      bad++; $display("FAIL free_run_done got count=%0d at=%0d want count=1 at=%0d", done_cnt, done_at, TOTAL);
    end
    tick();
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL free_run_stop got running=%b want 0", running);
    end
  endtask

  task automatic test_single_step();
    int active = 0;
    int dones  = 0;
    single_step = 1'b1;
    tick();
    single_step = 1'b0;
    for (int i = 0; i < TOTAL + 8; i++) begin
      if (running) active++;
      if (instr_done) dones++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL single_step cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
      if (i == 3) single_step = 1'b1;
      if (i == 4) single_step = 1'b0;
      tick();
    end
    total++;
    if (active !== TOTAL || dones !== 1 || running !== 1'b0 || step !== N'(1)) begin
      bad++; $display("FAIL single_step_summary got active=%0d done=%0d running=%b step=%b want %0d 1 0 %b",
                      active, dones, running, step, TOTAL, N'(1));
    end
  endtask

  task automatic test_halt();
    int active = 0;
    run = 1'b1;
    for (int i = 1; i <= TOTAL + 10; i++) begin
      if (i == 10) halt_req = 1'b1;
      if (i == 15) run = 1'b0;
      tick();
      if (running) active++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL halt cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    halt_req = 1'b0;
    total++;
    if (active !== TOTAL || running !== 1'b0 || step !== N'(1)) begin
      bad++; $display("FAIL halt_summary got active=%0d running=%b want active=%0d running=0", active, running, TOTAL);
    end
  endtask

  task automatic test_back_to_back();
    run = 1'b1;
    for (int i = 1; i <= TOTAL; i++) tick();
    halt_req = 1'b1;
    tick();
    total++;
    if (running !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL halt_boundary got=%b want=%b", obs_vec(), exp_vec());
    end
    halt_req = 1'b0;
    single_step = 1'b1;
    tick();
    single_step = 1'b0;
    for (int i = 0; i < TOTAL + 12; i++) begin
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL run_wins cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL run_wins_continue got running=%b want 1", running);
    end
    run = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] one;
    one = 1;
    run = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    total++;
    if (step !== (one << 4)) begin
      bad++; $display("FAIL reset_mid_setup got step=%b want %b", step, one << 4);
    end
`ifdef STEP_SEQ_INSTR_COUNT_EN
    total++;
    if (instr_count !== 16'(m_count)) begin
      bad++; $display("FAIL count_before_reset got=%0d want=%0d", instr_count, m_count);
    end
`endif
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== {3'b000, one, 2'b00}) begin
      bad++; $display("FAIL reset_mid got=%b want=%b", obs_vec(), {3'b000, one, 2'b00});
    end
`ifdef STEP_SEQ_INSTR_COUNT_EN
    total++;
    if (instr_count !== 16'd0) begin
      bad++; $display("FAIL count_cleared got=%0d want=0", instr_count);
    end
`endif
    run = 1'b0;
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec() || instr_done !== 1'b0) begin
        bad++; $display("FAIL reset_mid_idle cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 37 == 0) run = ($urandom_range(0, 99) < 60);
      halt_req    = ($urandom_range(0, 99) < 3);
      single_step = ($urandom_range(0, 99) < 5);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
`ifdef STEP_SEQ_INSTR_COUNT_EN
      total++;
      if (instr_count !== 16'(m_count)) begin
        bad++; $display("FAIL random_count cyc=%0d got=%0d want=%0d", i, instr_count, m_count);
      end
`endif
    end
    run = 1'b0; halt_req = 1'b0; single_step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter: NUM_STEPS, default 7, number of one-hot steps per instruction (legal 2..8).
REQ-002 SHALL have port: sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: run  input  1  level; 1 = free-run instructions.
REQ-005 SHALL have port: halt_req  input  1  level; stop at end of current instruction.
REQ-006 SHALL have port: single_step  input  1  one-cycle pulse; execute exactly one instruction while stopped.
REQ-007 SHALL have port: clk  output  1  derived CPU clock.
REQ-008 SHALL have port: clk_e  output  1  enable phase.
REQ-009 SHALL have port: clk_s  output  1  set phase.
REQ-010 SHALL have port: step  output  NUM_STEPS  one-hot step; bit 0 = step 1.
REQ-011 SHALL have port: instr_done  output  1  one-sys_clk pulse on completion of the last step.
REQ-012 SHALL have port: running  output  1  1 in RUNNING or DRAINING.

Function
REQ-013 SHALL keep a 2-bit phase counter advancing 0->1->2->3->0 each sys_clk while not STOPPED.
REQ-014 SHALL decode phases: 0: clk=1,e=1,s=0; 1: clk=1,e=1,s=1; 2: clk=0,e=1,s=0; 3: clk=0,e=0,s=0.
REQ-015 SHALL, in STOPPED, hold phase=0 and force clk, clk_e, clk_s to 0.
REQ-016 SHALL advance step one position on the phase 3->0 transition; last step wraps to step 1.
REQ-017 SHALL assert instr_done for exactly the sys_clk cycle in which last step and phase 3 coincide.
REQ-018 SHALL implement states STOPPED, RUNNING, DRAINING.
REQ-019 STOPPED: run=1 -> RUNNING; else single_step=1 -> DRAINING; run wins if both; phase 0 of step 1 appears one sys_clk after the request.
REQ-020 RUNNING: halt_req=1 or run=0 -> DRAINING, unless that cycle is last step/phase 3, then -> STOPPED directly.
REQ-021 DRAINING: on last step/phase 3 -> STOPPED with step = step 1; halt_req, run, single_step ignored until then.
REQ-022 SHALL ignore single_step outside STOPPED.
REQ-023 SHALL never produce a partial instruction: every entry to STOPPED occurs after a full last-step phase 3.
REQ-024 step SHALL remain exactly one-hot at all times.

Reset
REQ-025 reset SHALL asynchronously force STOPPED, phase=0, step=1 (bit 0 set), clk=clk_e=clk_s=0, instr_done=0, running=0.
REQ-026 reset mid-instruction SHALL abort immediately; no instr_done is produced for the aborted instruction.
REQ-027 after reset release, operation SHALL resume only on a new run or single_step.

Configuration
REQ-028 With macro STEP_SEQ_INSTR_COUNT_EN defined, SHALL add output instr_count (16 bits), cleared by reset, incremented on each instr_done, wrapping 0xFFFF->0x0000.
REQ-029 Without STEP_SEQ_INSTR_COUNT_EN, instr_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, run=1 for 28 sys_clk -> clk_e/clk_s follow 1110/0100 pattern, steps 1..7 each 4 cycles, one instr_done at cycle 28.
REQ-031 Stopped, single_step pulse -> exactly 28 active sys_clk, one instr_done, running=0, step=7'b0000001 afterward.
REQ-032 Running, halt_req raised in step 3 -> completes step 7 phase 3, stops; no step 1 phase 0 follows.
REQ-033 halt_req raised exactly at step 7 phase 3 -> STOPPED next cycle; run and single_step same cycle while stopped -> free-run.
REQ-034 reset asserted mid-step 5 -> all outputs reset asynchronously, no instr_done; instr_count (if enabled) unchanged from prior value then cleared.
REQ-035 STEP_SEQ_INSTR_COUNT_EN defined, 65537 instructions -> instr_count = 0x0001.
